// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 command scheduler.
// The window-setup byte sequence lives here so the scheduler only indexes it.
package ili9341_pkg;

    typedef enum logic [3:0] {
        ST_RST_LO,
        ST_RST_WAIT,
        ST_FETCH,
        ST_SEND,
        ST_DELAY,
        ST_IDLE,
        ST_WIN,
        ST_PIX_WAIT,
        ST_PIX_HI,
        ST_PIX_LO
    } state_t;

    localparam logic [1:0] OP_CMD   = 2'b00;
    localparam logic [1:0] OP_DATA  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;

    localparam logic [3:0] WIN_LAST_IDX = 4'd10;

    // Returns {dc, byte} for position idx of the full-frame window setup.
    function automatic logic [8:0] win_entry(input logic [3:0]  idx,
                                             input logic [15:0] wm1,
                                             input logic [15:0] hm1);
        logic [8:0] e;
        case (idx)
            4'd0:    e = {1'b0, CMD_CASET};
            4'd1:    e = {1'b1, 8'h00};
            4'd2:    e = {1'b1, 8'h00};
            4'd3:    e = {1'b1, wm1[15:8]};
            4'd4:    e = {1'b1, wm1[7:0]};
            4'd5:    e = {1'b0, CMD_PASET};
            4'd6:    e = {1'b1, 8'h00};
            4'd7:    e = {1'b1, 8'h00};
            4'd8:    e = {1'b1, hm1[15:8]};
            4'd9:    e = {1'b1, hm1[7:0]};
            default: e = {1'b0, CMD_RAMWR};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ili9341_init_rom.sv
// Panel power-on command list as a combinational lookup: {op[1:0], val[7:0]}.
// Delay values are in DELAY_UNIT_CYC units as interpreted by the scheduler.
module ili9341_init_rom
    import ili9341_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic [AW-1:0] addr,
    output logic [9:0]    entry
);

    always_comb begin
        entry = {OP_END, 8'h00};
        case (int'(addr))
            0:       entry = {OP_CMD,   CMD_SWRESET};
            1:       entry = {OP_DELAY, 8'd5};
            2:       entry = {OP_CMD,   CMD_SLPOUT};
            3:       entry = {OP_DELAY, 8'd120};
            4:       entry = {OP_CMD,   CMD_COLMOD};
            5:       entry = {OP_DATA,  8'h55};
            6:       entry = {OP_CMD,   CMD_MADCTL};
            7:       entry = {OP_DATA,  8'h48};
            8:       entry = {OP_CMD,   CMD_DISPON};
            default: entry = {OP_END,   8'h00};
        endcase
    end

endmodule

// File: rtl/ili9341_cmd_sched.sv
// ILI9341 scheduler: hardware reset, init ROM replay with delays, then
// per-request frame streaming (window setup, RAMWR, RGB565 pixels).
module ili9341_cmd_sched
    import ili9341_pkg::*;
#(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int RST_PULSE_CYC  = 10000,
    parameter int RST_WAIT_CYC   = 120000,
    parameter int DELAY_UNIT_CYC = 1000,
    parameter int ROM_DEPTH      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  tx_data,
    output logic        tx_dc,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        lcd_rst_n,
    output logic        init_done,
    output logic        frame_done,
    output logic        busy
);

    localparam int          AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam logic [16:0] PIX_TOTAL = 17'(WIDTH * HEIGHT);
    localparam logic [15:0] WM1       = 16'(WIDTH - 1);
    localparam logic [15:0] HM1       = 16'(HEIGHT - 1);

    state_t        state_reg, state_next;
    logic [31:0]   cnt_reg, cnt_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [7:0]    byte_reg, byte_next;
    logic          dc_reg, dc_next;
    logic [3:0]    win_idx_reg, win_idx_next;
    logic [15:0]   pix_reg, pix_next;
    logic [16:0]   pix_cnt_reg, pix_cnt_next;
    logic          pending_reg, pending_next;
    logic          init_done_reg, init_done_next;
    logic          frame_done_reg, frame_done_next;
    logic          pix_ready_reg;
    logic          lcd_rst_n_reg;

    logic [9:0]    rom_entry;
    logic [1:0]    rom_op;
    logic [7:0]    rom_val;
    logic [AW-1:0] addr_inc;
    logic [8:0]    win_e;

    ili9341_init_rom #(
        .AW(AW)
    ) u_rom (
        .addr  (addr_reg),
        .entry (rom_entry)
    );

    assign rom_op   = rom_entry[9:8];
    assign rom_val  = rom_entry[7:0];
    assign addr_inc = (addr_reg == AW'(ROM_DEPTH - 1)) ? '0 : addr_reg + AW'(1);
    assign win_e    = win_entry(win_idx_reg, WM1, HM1);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        byte_next       = byte_reg;
        dc_next         = dc_reg;
        win_idx_next    = win_idx_reg;
        pix_next        = pix_reg;
        pix_cnt_next    = pix_cnt_reg;
        pending_next    = pending_reg;
        init_done_next  = init_done_reg;
        frame_done_next = 1'b0;

        // Requests arriving before init completes are held until IDLE.
        if (frame_start && !init_done_reg) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            ST_RST_LO: begin
                if (cnt_reg == 32'd0) begin
                    state_next = ST_RST_WAIT;
                    cnt_next   = 32'(RST_WAIT_CYC - 1);
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_reg == 32'd0) begin
                    state_next = ST_FETCH;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            ST_FETCH: begin
                case (rom_op)
                    OP_CMD, OP_DATA: begin
                        byte_next  = rom_val;
                        dc_next    = rom_op[0];
                        state_next = ST_SEND;
                    end
                    OP_DELAY: begin
                        if (rom_val == 8'd0) begin
                            addr_next = addr_inc;
                        end else begin
                            cnt_next   = 32'(rom_val) * 32'(DELAY_UNIT_CYC) - 32'd1;
                            state_next = ST_DELAY;
                        end
                    end
                    default: begin
                        init_done_next = 1'b1;
                        state_next     = ST_IDLE;
                    end
                endcase
            end
            ST_SEND: begin
                if (tx_ready) begin
                    addr_next  = addr_inc;
                    state_next = ST_FETCH;
                end
            end
            ST_DELAY: begin
                if (cnt_reg == 32'd0) begin
                    addr_next  = addr_inc;
                    state_next = ST_FETCH;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            ST_IDLE: begin
                if (pending_reg || frame_start) begin
                    pending_next = 1'b0;
                    win_idx_next = 4'd0;
                    state_next   = ST_WIN;
                end
            end
            ST_WIN: begin
                if (tx_ready) begin
                    if (win_idx_reg == WIN_LAST_IDX) begin
                        pix_cnt_next = 17'd0;
                        state_next   = ST_PIX_WAIT;
                    end else begin
                        win_idx_next = win_idx_reg + 4'd1;
                    end
                end
            end
            ST_PIX_WAIT: begin
                if (pix_valid && pix_ready_reg) begin
                    pix_next   = pix_data;
                    state_next = ST_PIX_HI;
                end
            end
            ST_PIX_HI: begin
                if (tx_ready) begin
                    state_next = ST_PIX_LO;
                end
            end
            ST_PIX_LO: begin
                if (tx_ready) begin
                    if (pix_cnt_reg + 17'd1 == PIX_TOTAL) begin
                        pix_cnt_next    = 17'd0;
                        frame_done_next = 1'b1;
                        state_next      = ST_IDLE;
                    end else begin
                        pix_cnt_next = pix_cnt_reg + 17'd1;
                        state_next   = ST_PIX_WAIT;
                    end
                end
            end
            default: state_next = ST_RST_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RST_LO;
            cnt_reg        <= 32'(RST_PULSE_CYC - 1);
            addr_reg       <= '0;
            byte_reg       <= 8'h00;
            dc_reg         <= 1'b0;
            win_idx_reg    <= 4'd0;
            pix_reg        <= 16'h0000;
            pix_cnt_reg    <= 17'd0;
            pending_reg    <= 1'b0;
            init_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            pix_ready_reg  <= 1'b0;
            lcd_rst_n_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            byte_reg       <= byte_next;
            dc_reg         <= dc_next;
            win_idx_reg    <= win_idx_next;
            pix_reg        <= pix_next;
            pix_cnt_reg    <= pix_cnt_next;
            pending_reg    <= pending_next;
            init_done_reg  <= init_done_next;
            frame_done_reg <= frame_done_next;
            pix_ready_reg  <= (state_next == ST_PIX_WAIT);
            lcd_rst_n_reg  <= (state_next != ST_RST_LO);
        end
    end

    // Byte outputs decode from registered state only, so they hold steady under backpressure.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_dc    = 1'b0;
        case (state_reg)
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = byte_reg;
                tx_dc    = dc_reg;
            end
            ST_WIN: begin
                tx_valid = 1'b1;
                tx_data  = win_e[7:0];
                tx_dc    = win_e[8];
            end
            ST_PIX_HI: begin
                tx_valid = 1'b1;
                tx_data  = pix_reg[15:8];
                tx_dc    = 1'b1;
            end
            ST_PIX_LO: begin
                tx_valid = 1'b1;
                tx_data  = pix_reg[7:0];
                tx_dc    = 1'b1;
            end
            default: ;
        endcase
    end

    assign pix_ready  = pix_ready_reg;
    assign lcd_rst_n  = lcd_rst_n_reg;
    assign init_done  = init_done_reg;
    assign frame_done = frame_done_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule
